// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter: round-robin sharing of the register file read mux with a registered response
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   req_valid   per-requester request pending
//   req_addr    per-requester 5-bit register address, requester i at [5*i+4:5*i]
//   req_ready   one-hot grant, zero while reset or while a held response is not consumed
//   rd_sel      select to the 32:1 read mux (winner's address, 0 when idle)
//   rd_data     read mux output for rd_sel
//   resp_valid  response register holds data
//   resp_id     requester that owns the response
//   resp_data   captured read data
//   resp_ready  consumer accepts the response
module regfile_read_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [5*NUM_REQ-1:0] req_addr,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [4:0]           rd_sel,
    input  logic [31:0]          rd_data,
    output logic                 resp_valid,
    output logic [ID_W-1:0]      resp_id,
    output logic [31:0]          resp_data,
    input  logic                 resp_ready
);
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] resp_id_q, resp_id_d;
    logic [31:0]     resp_data_q, resp_data_d;
    logic            resp_valid_q, resp_valid_d;
    logic [ID_W-1:0] winner;
    logic            any_valid;
    logic            can_accept;
    logic            accept;
    int              idx;
    // Scan from the lowest priority offset down so the offset closest to rr_ptr wins.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                winner    = ID_W'(idx);
                any_valid = 1'b1;
            end
        end
    end
    assign can_accept = !resp_valid_q || resp_ready;
    assign accept     = !reset && any_valid && can_accept;
    assign req_ready  = accept ? NUM_REQ'(1) << winner : '0;
    assign rd_sel     = any_valid ? req_addr[5*winner +: 5] : 5'd0;
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        resp_valid_d = resp_valid_q && !resp_ready;
        if (accept) begin
            rr_ptr_d     = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            resp_id_d    = winner;
            resp_data_d  = (ZERO_R0 != 0 && rd_sel == 5'd0) ? 32'h0 : rd_data;
            resp_valid_d = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q     <= '0;
            resp_id_q    <= '0;
            resp_data_q  <= 32'h0;
            resp_valid_q <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            resp_valid_q <= resp_valid_d;
        end
    end
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
endmodule

// File: tb/tb_regfile_read_arbiter.sv
// tb_regfile_read_arbiter: directed and random checks of the arbiter against a behavioural model
module tb_regfile_read_arbiter;
    localparam int N = 4;
    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  rv;
    logic [5*N-1:0] ra;
    logic          resp_ready;
    logic [N-1:0]  req_ready, req_ready0;
    logic [4:0]    rd_sel, rd_sel0;
    logic [31:0]   rd_data, rd_data0;
    logic          resp_valid, resp_valid0;
    logic [1:0]    resp_id, resp_id0;
    logic [31:0]   resp_data, resp_data0;
    logic [31:0]   mem [32];
    int            checks = 0;
    int            fails = 0;
    int            m_rr;
    bit            m_valid;
    int            m_id;
    logic [31:0]   m_data, m_data0;
    logic [N-1:0]  acc_mask;
    always #5 clk = ~clk;
    assign rd_data  = mem[rd_sel];
    assign rd_data0 = mem[rd_sel0];
    regfile_read_arbiter #(.NUM_REQ(N), .ID_W(2), .ZERO_R0(1)) dut (
        .clk(clk), .reset(rst), .req_valid(rv), .req_addr(ra), .req_ready(req_ready),
        .rd_sel(rd_sel), .rd_data(rd_data), .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_data(resp_data), .resp_ready(resp_ready)
    );
    regfile_read_arbiter #(.NUM_REQ(N), .ID_W(2), .ZERO_R0(0)) dut0 (
        .clk(clk), .reset(rst), .req_valid(rv), .req_addr(ra), .req_ready(req_ready0),
        .rd_sel(rd_sel0), .rd_data(rd_data0), .resp_valid(resp_valid0), .resp_id(resp_id0),
        .resp_data(resp_data0), .resp_ready(resp_ready)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    // One clock cycle: check combinational grant/select, advance the model, check the response.
    task automatic step();
        int w;
        bit acc;
        logic [N-1:0] er;
        logic [4:0] es;
        #1;
        w = -1;
        for (int k = 0; k < N; k++)
            if (w < 0 && rv[(m_rr + k) % N]) w = (m_rr + k) % N;
        acc = !rst && w >= 0 && (!m_valid || resp_ready);
        er = acc ? N'(1 << w) : '0;
        es = (w >= 0) ? ra[w*5 +: 5] : 5'd0;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("rd_sel", 32'(rd_sel), 32'(es));
        chk("req_ready0", 32'(req_ready0), 32'(er));
        acc_mask = er;
        if (rst) begin
            m_rr = 0; m_valid = 0; m_id = 0; m_data = 0; m_data0 = 0;
        end else if (acc) begin
            m_data  = (es == 0) ? 32'h0 : mem[es];
            m_data0 = mem[es];
            m_id    = w;
            m_valid = 1;
            m_rr    = (w + 1) % N;
        end else if (resp_ready) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        chk("resp_valid", 32'(resp_valid), 32'(m_valid));
        chk("resp_id", 32'(resp_id), 32'(m_id));
        chk("resp_data", resp_data, m_data);
        chk("resp_data0", resp_data0, m_data0);
    endtask
    function automatic logic [5*N-1:0] set_addr(input logic [5*N-1:0] a, input int i, input logic [4:0] v);
        logic [5*N-1:0] r;
        r = a;
        r[i*5 +: 5] = v;
        return r;
    endfunction
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = {16'hDEAD, 16'(i)};
        rst = 1; rv = '1; ra = {5'd4, 5'd3, 5'd2, 5'd1}; resp_ready = 1;
        m_rr = 0; m_valid = 0; m_id = 0; m_data = 0; m_data0 = 0; acc_mask = '0;
        @(posedge clk);
        #1;
        // reset held two cycles with all requesters valid
        step();
        step();
        rst = 0;
        rv = 4'b0001;
        step();
        chk("first_grant_id", 32'(resp_id), 32'd0);
        // single read from requester 2, address 7
        rv = 4'b0100; ra = set_addr(ra, 2, 5'd7);
        step();
        chk("single_data", resp_data, 32'hDEAD0007);
        chk("single_id", 32'(resp_id), 32'd2);
        rv = '0;
        step();
        // round robin from a fresh reset
        rst = 1; step(); rst = 0;
        rv = '1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rr_order", 32'(resp_id), 32'(i % N));
        end
        // backpressure: three stalled cycles, then resume
        resp_ready = 0;
        for (int i = 0; i < 3; i++) step();
        chk("bp_hold_id", 32'(resp_id), 32'd1);
        resp_ready = 1;
        step();
        chk("bp_resume_id", 32'(resp_id), 32'd2);
        // register zero handling on both parameterisations
        mem[0] = 32'hFFFFFFFF;
        rv = 4'b1000; ra = set_addr(ra, 3, 5'd0);
        step();
        chk("r0_zero", resp_data, 32'h0);
        chk("r0_raw", resp_data0, 32'hFFFFFFFF);
        // reset while a response is held
        rv = 4'b0010;
        step();
        resp_ready = 0;
        rv = 4'b0100;
        step();
        rst = 1;
        step();
        chk("mid_reset_valid", 32'(resp_valid), 32'd0);
        rst = 0; resp_ready = 1;
        step();
        chk("mid_reset_regrant", 32'(resp_id), 32'd2);
        // random traffic honouring the hold-until-accepted rule
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (!rv[i] || acc_mask[i]) begin
                    rv[i] = 1'($urandom_range(0, 1));
                    ra = set_addr(ra, i, 5'($urandom_range(0, 31)));
                end
            resp_ready = ($urandom_range(0, 9) < 7);
            rst = ($urandom_range(0, 99) == 0);
            mem[$urandom_range(0, 31)] = $urandom;
            step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/regfile_read_arbiter.md
# regfile_read_arbiter

Shares the register file's single 32-bit, 32-to-1 read mux among up to NUM_REQ requesters, for example the decode stage, a debug port and a trace unit. It arbitrates requests round-robin and drives the mux select. It captures the mux output into a registered response with a valid/ready handshake. It sits between the requesters and the combinational read-mux tree.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- ID_W, 2: width of requester index; must equal ceil(log2(NUM_REQ)).
- ZERO_R0, 1: when 1, a read of address 0 returns 32'h0 regardless of mux output.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  request pending, one bit per requester.
- req_addr  input  5*NUM_REQ  register address; requester i uses bits [5*i+4:5*i].
- req_ready  output  NUM_REQ  one-hot grant; request i is accepted in a cycle where req_valid[i] and req_ready[i] are both 1.
- rd_sel  output  5  select to the 32:1 read mux, combinational.
- rd_data  input  32  mux output, combinational function of rd_sel.
- resp_valid  output  1  response register holds data.
- resp_id  output  ID_W  index of the requester that owns the response.
- resp_data  output  32  captured read data.
- resp_ready  input  1  consumer accepts the response.

## Operation
- State: rr_ptr (ID_W bits, highest-priority index), resp_valid, resp_id, resp_data.
- can_accept = !resp_valid || resp_ready.
- Winner: the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … wrapping modulo NUM_REQ.
- req_ready[winner] = can_accept; all other req_ready bits are 0. With no valid request, req_ready is all zeros.
- rd_sel = req_addr of the winner when any request is valid, else 5'd0. It does not depend on can_accept.
- On accept:
  - resp_data <= (ZERO_R0 && rd_sel==0) ? 0 : rd_data.
  - resp_id <= winner.
  - resp_valid <= 1.
  - rr_ptr <= (winner+1) mod NUM_REQ.
- If there is no accept and resp_ready=1, resp_valid <= 0. resp_data and resp_id hold their last values.
- If there is no accept and resp_ready=0, all state holds. The response stays stable until consumed.
- rr_ptr advances only on an accept. Idle cycles and stall cycles do not move it.
- Fairness: a continuously valid requester is granted within NUM_REQ accepts.
- Requesters must hold req_valid and req_addr stable until accepted. The arbiter does not check this.
- req_valid bits for i >= NUM_REQ do not exist. Indices outside 0..NUM_REQ-1 are never granted.

## Timing
- Reset (reset=1 at an edge) sets:
  - resp_valid=0, resp_id=0, resp_data=32'h0, rr_ptr=0.
  - req_ready is all zeros while reset=1, overriding arbitration.
- Reset mid-operation discards any held response with no handshake. A requester waiting on req_ready must keep req_valid asserted.
- Latency: a request accepted at edge N has resp_valid=1 with its data after edge N.
- Throughput: one accept per cycle while resp_ready=1, including back-to-back accepts with resp_valid=1 and resp_ready=1 in the same cycle.
- Simultaneous consume and accept: the new response replaces the old one and resp_valid stays 1.
- Backpressure: resp_valid=1 and resp_ready=0 force req_ready to all zeros. rd_sel still tracks the winner.
- rd_data is sampled at the accept edge only. Later changes to the register file do not alter a held resp_data.

## Test plan
- Reset: assert reset 2 cycles with req_valid=4'b1111 -> req_ready=0, resp_valid=0, resp_data=0, resp_id=0; the first accept after release goes to requester 0.
- Single read: req 2 with addr 7 and rd_data model returning 32'hDEAD0007 for sel 7 -> rd_sel=7 and req_ready=4'b0100 that cycle; next cycle resp_valid=1, resp_id=2, resp_data=32'hDEAD0007.
- Round-robin: all 4 requesters held valid and resp_ready=1 -> grant order 0,1,2,3,0,1 on consecutive cycles, one response per cycle.
- Backpressure: resp_ready=0 for 3 cycles with requests pending -> req_ready=0, response stable and rr_ptr frozen; resp_ready=1 -> next grant resumes at the expected requester.
- R0 handling: ZERO_R0=1, addr 0, rd_data=32'hFFFFFFFF -> resp_data=0. With ZERO_R0=0 the same stimulus gives resp_data=32'hFFFFFFFF.
- Reset mid-operation: resp_valid=1 and resp_ready=0, assert reset one cycle -> resp_valid=0 and rr_ptr=0 after the edge; a pending requester is re-granted.
